// File: rtl/wb_pkg.sv
// Shared widths and types for the writeback arbiter slice.
// Declarations only: no latency and no flow control of its own.
package wb_pkg;

   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_PIPE = 2'd1,
      SEL_MD   = 2'd2
   } wb_sel_e;

   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_W-1:0] rd);
      logic [NUM_REGS-1:0] oh;
      oh     = '0;
      oh[rd] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries, also exposing every slot's valid/rd.
// Latency: push visible at head the next cycle; backpressure: push ignored when full, pop ignored when empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   ctrl_reset_n,
   input  logic                   push,
   input  wb_entry_t              push_dat,
   input  logic                   pop,
   output wb_entry_t              head,
   output logic                   full,
   output logic                   empty,
   output logic [DEPTH-1:0]       ent_vld,
   output logic [DEPTH*REG_W-1:0] ent_rd
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_idx, rd_idx;
   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic             push_ok, pop_ok;

   assign wr_idx  = wr_ptr_q[AW-1:0];
   assign rd_idx  = rd_ptr_q[AW-1:0];
   // The extra pointer bit distinguishes a full ring from an empty one.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_q[rd_idx];
   assign ent_vld = vld_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_rd
      assign ent_rd[g*REG_W +: REG_W] = mem_q[g].rd;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      vld_d    = vld_q;
      if (pop_ok) begin
         rd_ptr_d      = rd_ptr_q + (AW+1)'(1);
         vld_d[rd_idx] = 1'b0;
      end
      if (push_ok) begin
         wr_ptr_d      = wr_ptr_q + (AW+1)'(1);
         mem_d[wr_idx] = push_dat;
         vld_d[wr_idx] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline writebacks with queued multdiv results onto the single register-file write port.
// Latency: pipe 1 cycle, multdiv >= 2 cycles; backpressure: md_ready = !full, pipe_stall pulses after starvation.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int MD_DEPTH   = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic        clock,
   input  logic        ctrl_reset_n,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        md_valid,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
   output logic        md_ready,
   output logic        pipe_stall,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic [31:0] busy_mask
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   wb_entry_t                 md_entry, md_head;
   logic                      md_full, md_empty, md_push, md_pop;
   logic [MD_DEPTH-1:0]       md_ent_vld;
   logic [MD_DEPTH*REG_W-1:0] md_ent_rd;
   logic                      pipe_ok;
   wb_sel_e                   sel;

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              pipe_stall_q, pipe_stall_d;
   logic              we_q, we_d;
   logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              out_md_q, out_md_d;
   logic [NUM_REGS-1:0] busy_c;

   // Ready depends only on stored occupancy, never on this cycle's pop.
   assign md_ready = !md_full;
   assign md_push  = md_valid && !md_full && (md_rd != '0);
   assign md_entry = '{rd: md_rd, data: md_data};
   assign pipe_ok  = pipe_valid && (pipe_rd != '0) && !pipe_stall_q;
   assign md_pop   = (sel == SEL_MD);

   wb_fifo #(
      .DEPTH (MD_DEPTH)
   ) u_md_fifo (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .push         (md_push),
      .push_dat     (md_entry),
      .pop          (md_pop),
      .head         (md_head),
      .full         (md_full),
      .empty        (md_empty),
      .ent_vld      (md_ent_vld),
      .ent_rd       (md_ent_rd)
   );

   always_comb begin
      sel = SEL_NONE;
      if (pipe_stall_q && !md_empty) begin
         sel = SEL_MD;
      end else if (pipe_ok) begin
         sel = SEL_PIPE;
      end else if (!md_empty) begin
         sel = SEL_MD;
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      pipe_stall_d = 1'b0;
      if (!md_empty && !md_pop) begin
         pipe_stall_d = (starve_cnt_q == CNT_W'(STARVE_LIM - 1));
         starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_LIM)) ? starve_cnt_q
                                                             : starve_cnt_q + CNT_W'(1);
      end
   end

   // Address and data hold when idle; only the enable drops.
   always_comb begin
      we_d      = 1'b0;
      out_md_d  = 1'b0;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      unique case (sel)
         SEL_PIPE: begin
            we_d      = 1'b1;
            wr_reg_d  = pipe_rd;
            wr_data_d = pipe_data;
         end
         SEL_MD: begin
            we_d      = 1'b1;
            out_md_d  = 1'b1;
            wr_reg_d  = md_head.rd;
            wr_data_d = md_head.data;
         end
         default: ;
      endcase
   end

   // Each register compares against every queued slot, so duplicates keep the bit alive.
   always_comb begin
      busy_c = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         for (int i = 0; i < MD_DEPTH; i++) begin
            if (md_ent_vld[i] && (md_ent_rd[i*REG_W +: REG_W] == REG_W'(r))) busy_c[r] = 1'b1;
         end
      end
      if (out_md_q) busy_c = busy_c | rd_onehot(wr_reg_q);
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         starve_cnt_q <= '0;
         pipe_stall_q <= 1'b0;
         we_q         <= 1'b0;
         wr_reg_q     <= '0;
         wr_data_q    <= '0;
         out_md_q     <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         pipe_stall_q <= pipe_stall_d;
         we_q         <= we_d;
         wr_reg_q     <= wr_reg_d;
         wr_data_q    <= wr_data_d;
         out_md_q     <= out_md_d;
      end
   end

   assign pipe_stall       = pipe_stall_q;
   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wr_reg_q;
   assign data_writeReg    = wr_data_q;
   assign busy_mask        = busy_c;

   // A stall always forces a pop, so it can never last two cycles.
   a_stall_pulse : assert property (@(posedge clock) disable iff (!ctrl_reset_n)
      pipe_stall_q |=> !pipe_stall_q);

   a_md_out_enabled : assert property (@(posedge clock) disable iff (!ctrl_reset_n)
      out_md_q |-> we_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

   localparam int MD_DEPTH   = 2;
   localparam int STARVE_LIM = 4;

   logic        clock = 1'b0;
   logic        ctrl_reset_n;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        md_ready;
   logic        pipe_stall;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [31:0] busy_mask;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   // Reference model: pending multdiv results plus what the write port shows.
   ent_t        mq[$];
   logic        m_we;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   logic        m_out_md;
   logic        m_stall;
   int          m_unserved;

   wb_arbiter #(
      .MD_DEPTH   (MD_DEPTH),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clock            (clock),
      .ctrl_reset_n     (ctrl_reset_n),
      .pipe_valid       (pipe_valid),
      .pipe_rd          (pipe_rd),
      .pipe_data        (pipe_data),
      .md_valid         (md_valid),
      .md_rd            (md_rd),
      .md_data          (md_data),
      .md_ready         (md_ready),
      .pipe_stall       (pipe_stall),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .busy_mask        (busy_mask)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] exp_busy();
      logic [31:0] b;
      b = '0;
      foreach (mq[i]) b[mq[i].rd] = 1'b1;
      if (m_out_md) b[m_reg] = 1'b1;
      return b;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_we       = 1'b0;
      m_reg      = '0;
      m_data     = '0;
      m_out_md   = 1'b0;
      m_stall    = 1'b0;
      m_unserved = 0;
   endtask

   task automatic idle_inputs();
      pipe_valid = 1'b0;
      pipe_rd    = '0;
      pipe_data  = '0;
      md_valid   = 1'b0;
      md_rd      = '0;
      md_data    = '0;
   endtask

   // One clock: compare DUT against the model mid-cycle, then advance the model.
   task automatic step();
      logic [31:0] eb;
      logic        pv, mv;
      logic [4:0]  prd, mrd;
      logic [31:0] pdat, mdat;
      bit          take_md, take_pipe, accept, n_stall;
      int          n_unserved;
      ent_t        hd;
      @(negedge clock);
      eb = exp_busy();
      checks++;
      if (md_ready !== (mq.size() < MD_DEPTH)) begin
         errors++;
         $display("FAIL md_ready: got %0b exp %0b", md_ready, (mq.size() < MD_DEPTH));
      end
      checks++;
      if (pipe_stall !== m_stall) begin
         errors++;
         $display("FAIL pipe_stall: got %0b exp %0b", pipe_stall, m_stall);
      end
      checks++;
      if (ctrl_writeEnable !== m_we) begin
         errors++;
         $display("FAIL write_enable: got %0b exp %0b", ctrl_writeEnable, m_we);
      end
      checks++;
      if (ctrl_writeReg !== m_reg) begin
         errors++;
         $display("FAIL write_reg: got %0d exp %0d", ctrl_writeReg, m_reg);
      end
      checks++;
      if (data_writeReg !== m_data) begin
         errors++;
         $display("FAIL write_data: got %08h exp %08h", data_writeReg, m_data);
      end
      checks++;
      if (busy_mask !== eb) begin
         errors++;
         $display("FAIL busy_mask: got %08h exp %08h", busy_mask, eb);
      end
      pv = pipe_valid; prd = pipe_rd; pdat = pipe_data;
      mv = md_valid;   mrd = md_rd;   mdat = md_data;
      take_md   = 0;
      take_pipe = 0;
      if (m_stall && mq.size() > 0) take_md = 1;
      else if (pv && prd != 0 && !m_stall) take_pipe = 1;
      else if (mq.size() > 0) take_md = 1;
      accept = mv && (mq.size() < MD_DEPTH);
      if (mq.size() > 0 && !take_md) begin
         n_unserved = m_unserved + 1;
         n_stall    = (n_unserved == STARVE_LIM);
      end else begin
         n_unserved = 0;
         n_stall    = 0;
      end
      @(posedge clock);
      if (take_md) begin
         hd       = mq.pop_front();
         m_we     = 1'b1;
         m_reg    = hd.rd;
         m_data   = hd.data;
         m_out_md = 1'b1;
      end else if (take_pipe) begin
         m_we     = 1'b1;
         m_reg    = prd;
         m_data   = pdat;
         m_out_md = 1'b0;
      end else begin
         m_we     = 1'b0;
         m_out_md = 1'b0;
      end
      if (accept && mrd != 0) mq.push_back('{rd: mrd, data: mdat});
      m_stall    = n_stall;
      m_unserved = n_unserved;
      #1;
   endtask

   task automatic test_reset();
      ctrl_reset_n = 1'b0;
      pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA5A5A5A5;
      md_valid   = 1'b1; md_rd   = 5'd4; md_data   = 32'h5A5A5A5A;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
         errors++;
         $display("FAIL reset_write_port: got we=%0b reg=%0d data=%08h exp 0/0/0",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      checks++;
      if (pipe_stall !== 1'b0 || busy_mask !== 32'd0 || md_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_status: got stall=%0b busy=%08h ready=%0b exp 0/0/1",
                  pipe_stall, busy_mask, md_ready);
      end
      @(negedge clock);
      idle_inputs();
      ctrl_reset_n = 1'b1;
      step();
      pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0BADF00D;
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h0BADF00D) begin
         errors++;
         $display("FAIL first_write: got we=%0b reg=%0d data=%08h exp 1/3/0badf00d",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_pipe();
      pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL pipe_write: got we=%0b reg=%0d data=%08h exp 1/5/deadbeef",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      pipe_rd = 5'd0; pipe_data = 32'h11111111;
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL pipe_r0: got we=%0b reg=%0d data=%08h exp 0/5/deadbeef",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_md();
      md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12345678;
      step();
      idle_inputs();
      checks++;
      if (busy_mask[7] !== 1'b1 || ctrl_writeEnable !== 1'b0) begin
         errors++;
         $display("FAIL md_enqueue: got busy7=%0b we=%0b exp 1/0", busy_mask[7], ctrl_writeEnable);
      end
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 || data_writeReg !== 32'h12345678
          || busy_mask[7] !== 1'b1) begin
         errors++;
         $display("FAIL md_write: got we=%0b reg=%0d data=%08h busy7=%0b exp 1/7/12345678/1",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask[7]);
      end
      step();
      checks++;
      if (busy_mask[7] !== 1'b0 || ctrl_writeEnable !== 1'b0) begin
         errors++;
         $display("FAIL md_retire: got busy7=%0b we=%0b exp 0/0", busy_mask[7], ctrl_writeEnable);
      end
      step();
   endtask

   task automatic test_full();
      bit prev_stall, st, acc, third_taken;
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h100;
      md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hA0;
      step();
      md_rd = 5'd11; md_data = 32'hA1; pipe_rd = 5'd2; pipe_data = 32'h101;
      step();
      checks++;
      if (md_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: got %0b exp 0", md_ready);
      end
      md_rd = 5'd12; md_data = 32'hA2;
      prev_stall  = 0;
      third_taken = 0;
      for (int c = 0; c < 20 && !third_taken; c++) begin
         if (!prev_stall) begin
            pipe_rd   = 5'(1 + (c % 5));
            pipe_data = 32'h200 + 32'(c);
         end
         st  = m_stall;
         acc = md_valid && (mq.size() < MD_DEPTH);
         step();
         prev_stall = st;
         if (acc) begin
            third_taken = 1;
            md_valid    = 1'b0;
         end
      end
      checks++;
      if (!third_taken) begin
         errors++;
         $display("FAIL full_third_accept: got not accepted exp accepted within 20 cycles");
      end
      idle_inputs();
      repeat (4) step();
   endtask

   task automatic test_starve();
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1000;
      md_valid = 1'b1; md_rd = 5'd20; md_data = 32'hC0FFEE00;
      step();
      md_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_early: got stall=%0b exp 0 at unserved cycle %0d", pipe_stall, k);
         end
         pipe_rd = 5'(1 + k); pipe_data = 32'h1000 + 32'(k);
         step();
      end
      checks++;
      if (pipe_stall !== 1'b1) begin
         errors++;
         $display("FAIL starve_stall: got %0b exp 1", pipe_stall);
      end
      pipe_rd = 5'd6; pipe_data = 32'hFEEDFACE;
      step();
      checks++;
      if (pipe_stall !== 1'b0 || ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd20
          || data_writeReg !== 32'hC0FFEE00 || busy_mask[20] !== 1'b1) begin
         errors++;
         $display("FAIL starve_md_write: got stall=%0b we=%0b reg=%0d data=%08h busy20=%0b exp 0/1/20/c0ffee00/1",
                  pipe_stall, ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask[20]);
      end
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd6 || data_writeReg !== 32'hFEEDFACE
          || busy_mask[20] !== 1'b0) begin
         errors++;
         $display("FAIL starve_held_pipe: got we=%0b reg=%0d data=%08h busy20=%0b exp 1/6/feedface/0",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask[20]);
      end
      idle_inputs();
      repeat (3) step();
   endtask

   task automatic test_r0_dup();
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h77777777;
      step();
      idle_inputs();
      checks++;
      if (md_ready !== 1'b1 || busy_mask !== 32'd0) begin
         errors++;
         $display("FAIL md_r0_accept: got ready=%0b busy=%08h exp 1/0", md_ready, busy_mask);
      end
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b0) begin
         errors++;
         $display("FAIL md_r0_nowrite: got we=%0b exp 0", ctrl_writeEnable);
      end
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
      md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h9000000A;
      step();
      pipe_rd = 5'd2; pipe_data = 32'h2;
      md_rd = 5'd9; md_data = 32'h9000000B;
      step();
      idle_inputs();
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h9000000A
          || busy_mask[9] !== 1'b1) begin
         errors++;
         $display("FAIL dup_first: got we=%0b reg=%0d data=%08h busy9=%0b exp 1/9/9000000a/1",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask[9]);
      end
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b1 || data_writeReg !== 32'h9000000B || busy_mask[9] !== 1'b1) begin
         errors++;
         $display("FAIL dup_second: got we=%0b data=%08h busy9=%0b exp 1/9000000b/1",
                  ctrl_writeEnable, data_writeReg, busy_mask[9]);
      end
      step();
      checks++;
      if (busy_mask[9] !== 1'b0) begin
         errors++;
         $display("FAIL dup_clear: got busy9=%0b exp 0", busy_mask[9]);
      end
      step();
   endtask

   task automatic test_reset_mid();
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h51;
      md_valid = 1'b1; md_rd = 5'd13; md_data = 32'hD13;
      step();
      pipe_rd = 5'd2; md_rd = 5'd14; md_data = 32'hD14;
      step();
      md_valid = 1'b0; pipe_rd = 5'd3;
      step();
      #2;
      ctrl_reset_n = 1'b0;
      #1;
      checks++;
      if (ctrl_writeEnable !== 1'b0 || busy_mask !== 32'd0 || md_ready !== 1'b1 || pipe_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got we=%0b busy=%08h ready=%0b stall=%0b exp 0/0/1/0",
                  ctrl_writeEnable, busy_mask, md_ready, pipe_stall);
      end
      @(posedge clock);
      @(negedge clock);
      idle_inputs();
      ctrl_reset_n = 1'b1;
      model_reset();
      repeat (4) step();
   endtask

   task automatic test_random();
      bit          prev_stall, st, acc;
      logic [31:0] eb;
      prev_stall = 0;
      idle_inputs();
      for (int c = 0; c < 4000; c++) begin
         int pct;
         pct = (c / 500) % 2 == 0 ? 90 : 35;
         if (!(pipe_valid && prev_stall)) begin
            eb         = exp_busy();
            pipe_valid = ($urandom_range(99) < pct);
            pipe_rd    = ($urandom_range(1) == 0) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
            pipe_data  = $urandom;
            if (pipe_rd != 0 && eb[pipe_rd]) pipe_valid = 1'b0;
         end
         if (!md_valid) begin
            md_valid = ($urandom_range(99) < 40);
            md_rd    = ($urandom_range(1) == 0) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
            md_data  = $urandom;
         end
         st  = m_stall;
         acc = md_valid && (mq.size() < MD_DEPTH);
         step();
         prev_stall = st;
         if (acc) md_valid = 1'b0;
      end
      idle_inputs();
      repeat (6) step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_pipe();
      test_md();
      test_full();
      test_starve();
      test_r0_dup();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the register file's single write port. Merges the in-order pipeline writeback stream with out-of-order completions from the multiply/divide unit, buffers multdiv results in a small queue, and drives registered `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg`. Publishes a busy mask so issue logic can stall on registers with a write still in flight.

## Interface
- `MD_DEPTH`, default 2: multdiv result queue entries, power of two, 2 or more.
- `STARVE_LIM`, default 4: consecutive cycles a non-empty queue may go unserved before the pipeline is stalled.
- `clock` in 1: single clock. All state updates on the rising edge.
- `ctrl_reset_n` in 1: reset, **asynchronous, active-low**.
- `pipe_valid` in 1: pipeline writeback request this cycle.
- `pipe_rd` in 5: destination register of the pipeline write.
- `pipe_data` in 32: pipeline write data.
- `md_valid` in 1: multdiv result available.
- `md_rd` in 5: multdiv destination register.
- `md_data` in 32: multdiv result.
- `md_ready` out 1: queue can accept a result. Equals `!full`.
- `pipe_stall` out 1: registered. Pipeline must hold its writeback this cycle.
- `ctrl_writeEnable` out 1: registered write enable to the register file.
- `ctrl_writeReg` out 5: registered write address.
- `data_writeReg` out 32: registered write data.
- `busy_mask` out 32: bit r is set while a multdiv write to r is queued or in the output register.

## Operation
- **Enqueue.** An md transfer occurs when `md_valid && md_ready`. If `md_rd == 0` the transfer completes but is discarded and nothing is enqueued.
- **Pipeline write qualification.** A pipeline write is eligible when `pipe_valid && pipe_rd != 0 && !pipe_stall`. Writes to r0 are dropped, and no write enable is issued for them.
- **Selection, in priority order each cycle:**
  - If `pipe_stall` is high and the queue is non-empty, pop the queue head.
  - Otherwise, if a pipeline write is eligible, issue it.
  - Otherwise, if the queue is non-empty, pop the head.
  - Otherwise, issue nothing.
- **Output register.** The selected write loads the output register. When nothing is selected, `ctrl_writeEnable` goes to 0 and `ctrl_writeReg`/`data_writeReg` hold their previous values.
- **Starvation counter (`starve_cnt`).**
  - Increments each cycle the queue is non-empty and is not popped.
  - Clears on any pop or when the queue is empty.
  - `pipe_stall` is registered high in the cycle following the one in which `starve_cnt` reaches `STARVE_LIM - 1` while still unserved. It is high for exactly one cycle.
- **Busy mask.**
  - A bit sets on enqueue.
  - It stays set while the entry sits in the output register.
  - It clears the cycle after that entry's write enable.
  - Duplicate queued rd values keep the bit set until the last matching entry retires. Track this with a per-entry compare, not a counter.
- **WAW ordering.** Upstream guarantees it never issues a pipeline write to a register whose `busy_mask` bit is set. The arbiter does not reorder or check for this.
- **Full queue.** When full, `md_ready` is 0 even if a pop occurs in the same cycle. There is no combinational ready-from-pop path.

## Timing
- **Reset values:**
  - `ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`, `pipe_stall`, `busy_mask` are all 0.
  - Queue is empty and `starve_cnt` is 0.
  - `md_ready` reads 1.
  - All inputs are ignored while `ctrl_reset_n` is low.
- **Pipeline latency.** Input in cycle N produces `ctrl_writeEnable` in cycle N+1.
- **Multdiv latency.** Enqueue at the edge ending cycle N, pop in cycle N+1, write enable in cycle N+2. Latency is longer while the pipeline has priority.
- **Simultaneous enqueue and pop.** Allowed when not full; occupancy is unchanged.
- **Pointer wrap-around.** Uses modulo `MD_DEPTH` with an extra wrap bit for full/empty detection.
- **Reset mid-operation.** Queued entries are lost without writeback, and the output write enable drops asynchronously.

## Structure
- **Package `wb_pkg`:**
  - `REG_W = 5`, `DATA_W = 32`, `NUM_REGS = 32`.
  - Packed struct `wb_entry_t {rd, data}`.
- **Sub-module `wb_fifo`:** synchronous FIFO of `wb_entry_t`, parameterised by depth. It exposes `push`, `pop`, `head`, `full`, `empty`, and per-entry valid/rd vectors for the busy mask.
- **Top level:** selection logic, starvation counter, output register and busy-mask reduction.

## Test plan
- **Reset:** hold `ctrl_reset_n` low with `pipe_valid=1`, `md_valid=1` -> all outputs 0, `md_ready=1`. Release -> first write appears 1 cycle after the next request.
- **Pipeline path:** `pipe_valid`, `pipe_rd=5`, `pipe_data=0xDEADBEEF` in cycle N -> cycle N+1 shows write enable 1, reg 5, data 0xDEADBEEF. Repeat with `pipe_rd=0` -> write enable stays 0.
- **Multdiv path:** `md_rd=7`, `md_data=0x12345678` enqueued with the pipeline idle -> `busy_mask[7]` set the next cycle, write in cycle N+2, bit clear in cycle N+3.
- **Full queue:** three md results back-to-back with `pipe_valid` held high -> `md_ready` goes 0 after two enqueues, third result held.
- **Starvation:** continuous pipeline writes, then one md result -> `pipe_stall` pulses one cycle after 4 unserved cycles. The md write is issued and the pipeline write held that cycle is issued next, with no loss.
- **r0 and duplicates:** md result with `md_rd=0` -> accepted, never written, busy bit 0. Two queued writes to r9 -> `busy_mask[9]` clears only after the second write.
